shaper_pulse_sequencer: RTL and testbench

SHAPER_PULSE_SEQUENCER -- requirements
Module: shaper_pulse_sequencer

---
 rtl/shaper_pulse_sequencer.sv | 158 +++++++++++++++
 tb/tb_shaper_pulse_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shaper_pulse_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shaper_pulse_sequencer
// Description : Gates a pulse shaper per trigger, captures the flat-top peak
//               and timestamp, and emits one event through a valid/ready
//               holding register with a saturating drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
module shaper_pulse_sequencer #(
    parameter int SIZE_SHAPER_DATA = 16,
    parameter int K                = 16,
    parameter int L                = 8,
    parameter int LATENCY          = 8,
    parameter int SIZE_TS          = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        trigger,
    input  logic [SIZE_SHAPER_DATA-1:0] shaper_data,
    output logic                        pulse_time,
    output logic                        event_valid,
    input  logic                        event_ready,
    output logic [SIZE_SHAPER_DATA-1:0] event_energy,
    output logic                        event_pileup,
    output logic [SIZE_TS-1:0]          event_timestamp,
    output logic                        busy,
    output logic [15:0]                 drop_count
);

    localparam int c_MAX_LK  = (LATENCY > K) ? LATENCY : K;
    localparam int c_MAX_LKL = (c_MAX_LK > L) ? c_MAX_LK : L;
    localparam int c_PH_MAX  = (c_MAX_LKL > (K + L)) ? c_MAX_LKL : (K + L);
    localparam int c_PH_W    = $clog2(c_PH_MAX + 1);

    localparam logic [c_PH_W-1:0] c_LD_SETTLE  = c_PH_W'(LATENCY - 1);
    localparam logic [c_PH_W-1:0] c_LD_SHAPE   = c_PH_W'(K - 1);
    localparam logic [c_PH_W-1:0] c_LD_PEAK    = c_PH_W'(L - 1);
    localparam logic [c_PH_W-1:0] c_LD_HOLDOFF = c_PH_W'(K + L - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_SHAPE   = 3'd2,
        S_PEAK    = 3'd3,
        S_DONE    = 3'd4,
        S_HOLDOFF = 3'd5
    } state_t;

    state_t                      r_state;
    logic [c_PH_W-1:0]           r_phase;
    logic [SIZE_TS-1:0]          r_ts_cnt;
    logic [SIZE_TS-1:0]          r_ts_lat;
    logic [SIZE_SHAPER_DATA-1:0] r_max;
    logic                        r_pile;
    logic                        r_pulse;
    logic                        r_valid;
    logic [SIZE_SHAPER_DATA-1:0] r_energy;
    logic                        r_pileup;
    logic [SIZE_TS-1:0]          r_timestamp;
    logic [15:0]                 r_drop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_phase     <= '0;
            r_ts_cnt    <= '0;
            r_ts_lat    <= '0;
            r_max       <= '0;
            r_pile      <= 1'b0;
            r_pulse     <= 1'b0;
            r_valid     <= 1'b0;
            r_energy    <= '0;
            r_pileup    <= 1'b0;
            r_timestamp <= '0;
            r_drop      <= '0;
        end else begin
            r_ts_cnt <= r_ts_cnt + SIZE_TS'(1);

            // A DONE load later in this block overrides this clear.
            if (r_valid && event_ready) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (trigger && enable) begin
                        r_state  <= S_SETTLE;
                        r_phase  <= c_LD_SETTLE;
                        r_pulse  <= 1'b1;
                        r_max    <= '0;
                        r_pile   <= 1'b0;
                        r_ts_lat <= r_ts_cnt;
                    end
                end
                S_SETTLE, S_SHAPE, S_PEAK: begin
                    if (!enable) begin
                        r_state <= S_HOLDOFF;
                        r_phase <= c_LD_HOLDOFF;
                        r_pulse <= 1'b0;
                    end else begin
                        if (r_state != S_SETTLE && trigger) begin
                            r_pile <= 1'b1;
                        end
                        if (r_state == S_PEAK && shaper_data > r_max) begin
                            r_max <= shaper_data;
                        end
                        if (r_phase != '0) begin
                            r_phase <= r_phase - c_PH_W'(1);
                        end else if (r_state == S_SETTLE) begin
                            r_state <= S_SHAPE;
                            r_phase <= c_LD_SHAPE;
                        end else if (r_state == S_SHAPE) begin
                            r_state <= S_PEAK;
                            r_phase <= c_LD_PEAK;
                        end else begin
                            r_state <= S_DONE;
                            r_pulse <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    if (!r_valid || event_ready) begin
                        r_valid     <= 1'b1;
                        r_energy    <= r_max;
                        r_pileup    <= r_pile;
                        r_timestamp <= r_ts_lat;
                    end else if (r_drop != 16'hFFFF) begin
                        r_drop <= r_drop + 16'd1;
                    end
                    r_state <= S_HOLDOFF;
                    r_phase <= c_LD_HOLDOFF;
                end
                S_HOLDOFF: begin
                    if (r_phase == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_phase <= r_phase - c_PH_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_pulse <= 1'b0;
                end
            endcase
        end
    end

    assign pulse_time      = r_pulse;
    assign event_valid     = r_valid;
    assign event_energy    = r_energy;
    assign event_pileup    = r_pileup;
    assign event_timestamp = r_timestamp;
    assign drop_count      = r_drop;
    assign busy            = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_shaper_pulse_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shaper_pulse_sequencer
// Description : Self-checking bench: directed scenarios plus random traffic
//               against a cycle-range event model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shaper_pulse_sequencer;

    localparam int c_K   = 16;
    localparam int c_L   = 8;
    localparam int c_LAT = 8;

    logic        clk = 1'b0;
    logic        reset, enable, trigger, event_ready;
    logic [15:0] shaper_data;

    logic        pulse_time, event_valid, event_pileup, busy;
    logic [15:0] event_energy, drop_count;
    logic [31:0] event_timestamp;

    logic        w_pulse_time, w_event_valid, w_event_pileup, w_busy;
    logic [15:0] w_event_energy, w_drop_count;
    logic [7:0]  w_event_timestamp;

    always #5 clk = ~clk;

    shaper_pulse_sequencer #(
        .SIZE_SHAPER_DATA(16), .K(c_K), .L(c_L), .LATENCY(c_LAT), .SIZE_TS(32)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .trigger(trigger),
        .shaper_data(shaper_data), .pulse_time(pulse_time),
        .event_valid(event_valid), .event_ready(event_ready),
        .event_energy(event_energy), .event_pileup(event_pileup),
        .event_timestamp(event_timestamp), .busy(busy), .drop_count(drop_count)
    );

    // Narrow timestamp copy so counter wrap is reachable in a short run.
    shaper_pulse_sequencer #(
        .SIZE_SHAPER_DATA(16), .K(c_K), .L(c_L), .LATENCY(c_LAT), .SIZE_TS(8)
    ) dut_w (
        .clk(clk), .reset(reset), .enable(enable), .trigger(trigger),
        .shaper_data(shaper_data), .pulse_time(w_pulse_time),
        .event_valid(w_event_valid), .event_ready(event_ready),
        .event_energy(w_event_energy), .event_pileup(w_event_pileup),
        .event_timestamp(w_event_timestamp), .busy(w_busy), .drop_count(w_drop_count)
    );

    int     n_checks = 0;
    int     n_errors = 0;
    longint cyc      = 0;

    // Event model: each accepted trigger defines cycle ranges for its phases.
    bit          m_act;
    longint      m_start, m_gate_end, m_done, m_end;
    logic [15:0] m_max;
    logic        m_pile;
    logic [31:0] m_ts;
    logic        m_valid;
    logic [15:0] m_energy;
    logic        m_pileup;
    logic [31:0] m_ts_o;
    int          m_drop;

    typedef struct {
        int          cyc;
        logic        trig;
        logic [15:0] data;
        logic        e_pulse;
        logic        e_busy;
        logic        e_valid;
        logic [15:0] e_energy;
        logic [31:0] e_ts;
    } vec_t;

    vec_t tab[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit m_busy();
        return m_act && cyc > m_start && cyc <= m_end;
    endfunction

    function automatic bit m_gate();
        return m_act && cyc > m_start && cyc <= m_gate_end;
    endfunction

    task automatic model_reset();
        m_act = 0; m_start = -1; m_gate_end = -1; m_done = -1; m_end = -1;
        m_max = '0; m_pile = 0; m_ts = '0;
        m_valid = 0; m_energy = '0; m_pileup = 0; m_ts_o = '0; m_drop = 0;
        cyc = 0;
    endtask

    task automatic model_check();
        check("busy",       busy,            m_busy());
        check("pulse_time", pulse_time,      m_gate());
        check("valid",      event_valid,     m_valid);
        check("energy",     event_energy,    m_energy);
        check("pileup",     event_pileup,    m_pileup);
        check("timestamp",  event_timestamp, m_ts_o);
        check("drop_count", drop_count,      16'(m_drop));
        check("w_busy",     w_busy,          m_busy());
        check("w_valid",    w_event_valid,   m_valid);
        check("w_timestamp", w_event_timestamp, m_ts_o[7:0]);
        check("w_drop",     w_drop_count,    16'(m_drop));
    endtask

    task automatic model_step(input logic trig, input logic en, input logic rdy,
                              input logic [15:0] data);
        bit busy_now, gate, shaping, peak;
        busy_now = m_busy();
        gate     = m_gate();
        shaping  = gate && cyc > m_start + c_LAT;
        peak     = gate && cyc > m_start + c_LAT + c_K;
        if (cyc == m_done) begin
            if (!m_valid || rdy) begin
                m_valid = 1; m_energy = m_max; m_pileup = m_pile; m_ts_o = m_ts;
            end else if (m_drop < 65535) begin
                m_drop++;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        if (gate && !en) begin
            m_gate_end = cyc; m_done = -1; m_end = cyc + c_K + c_L;
        end else begin
            if (peak && data > m_max) m_max = data;
            if (shaping && trig) m_pile = 1;
        end
        if (!busy_now && trig && en) begin
            m_act      = 1;
            m_start    = cyc;
            m_gate_end = cyc + c_LAT + c_K + c_L;
            m_done     = m_gate_end + 1;
            m_end      = m_done + c_K + c_L;
            m_max      = '0;
            m_pile     = 0;
            m_ts       = cyc[31:0];
        end
    endtask

    task automatic run_cycle(input logic trig, input logic en, input logic rdy,
                             input logic [15:0] data);
        model_check();
        trigger = trig; enable = en; event_ready = rdy; shaper_data = data;
        model_step(trig, en, rdy, data);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Cycle 0 begins at the release point; counter reads 0 throughout it.
    task automatic do_reset();
        reset = 1'b0; trigger = 1'b0; enable = 1'b1; event_ready = 1'b0; shaper_data = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pulse"},  pulse_time, 0);
        check({tag, "_valid"},  event_valid, 0);
        check({tag, "_energy"}, event_energy, 0);
        check({tag, "_pileup"}, event_pileup, 0);
        check({tag, "_ts"},     event_timestamp, 0);
        check({tag, "_drop"},   drop_count, 0);
        check({tag, "_busy"},   busy, 0);
        check({tag, "_w_valid"}, w_event_valid, 0);
    endtask

    initial begin
        logic        t;
        logic [15:0] d;
        int          rdy_mode;

        tab[0] = '{10, 1'b1, 16'd1000, 1'b0, 1'b0, 1'b0, 16'd0,    32'd0};
        tab[1] = '{11, 1'b0, 16'd3000, 1'b1, 1'b1, 1'b0, 16'd0,    32'd0};
        tab[2] = '{38, 1'b0, 16'd1200, 1'b1, 1'b1, 1'b0, 16'd0,    32'd0};
        tab[3] = '{42, 1'b0, 16'd1000, 1'b1, 1'b1, 1'b0, 16'd0,    32'd0};
        tab[4] = '{43, 1'b0, 16'd3000, 1'b0, 1'b1, 1'b0, 16'd0,    32'd0};
        tab[5] = '{44, 1'b0, 16'd3000, 1'b0, 1'b1, 1'b1, 16'd1200, 32'd10};
        tab[6] = '{67, 1'b0, 16'd3000, 1'b0, 1'b1, 1'b1, 16'd1200, 32'd10};
        tab[7] = '{68, 1'b0, 16'd3000, 1'b0, 1'b0, 1'b1, 16'd1200, 32'd10};

        reset = 1'b0; trigger = 1'b0; enable = 1'b1; event_ready = 1'b0; shaper_data = '0;
        #2;
        check_all_zero("reset");

        // Single pulse; data outside the flat-top is larger and must be ignored.
        do_reset();
        for (int c = 0; c < 80; c++) begin
            t = 1'b0;
            d = (c >= 35 && c <= 42) ? 16'd1000 : 16'd3000;
            for (int i = 0; i < 8; i++) begin
                if (tab[i].cyc == c) begin
                    t = tab[i].trig;
                    d = tab[i].data;
                    check("A_pulse",  pulse_time,      tab[i].e_pulse);
                    check("A_busy",   busy,            tab[i].e_busy);
                    check("A_valid",  event_valid,     tab[i].e_valid);
                    check("A_energy", event_energy,    tab[i].e_energy);
                    check("A_ts",     event_timestamp, tab[i].e_ts);
                    check("A_pileup", event_pileup,    1'b0);
                end
            end
            run_cycle(t, 1'b1, 1'b0, d);
        end

        // Pile-up in SHAPE, trigger in HOLDOFF ignored.
        do_reset();
        for (int c = 0; c < 120; c++) begin
            if (c == 44) begin
                check("B_valid",  event_valid, 1);
                check("B_pileup", event_pileup, 1);
                check("B_ts",     event_timestamp, 10);
                check("B_energy", event_energy, 42);
            end
            if (c == 68)  check("B_idle_after_holdoff", busy, 0);
            if (c == 110) check("B_no_second_event", event_valid, 0);
            run_cycle(c == 10 || c == 30 || c == 50, 1'b1, 1'b1, 16'(c));
        end

        // Backpressure: second event dropped.
        do_reset();
        for (int c = 0; c < 130; c++) begin
            if (c == 80)  check("C_held_ts", event_timestamp, 10);
            if (c == 80)  check("C_held_energy", event_energy, 16'(42 * 7));
            if (c == 101) check("C_drop_before", drop_count, 0);
            if (c == 102) begin
                check("C_drop_after", drop_count, 1);
                check("C_still_first", event_timestamp, 10);
                check("C_valid_held", event_valid, 1);
            end
            if (c == 120) check("C_valid_at_ready", event_valid, 1);
            if (c == 121) check("C_valid_cleared", event_valid, 0);
            run_cycle(c == 10 || c == 68, 1'b1, c == 120, 16'(c * 7));
        end

        // Accept and reload in the same DONE cycle.
        do_reset();
        for (int c = 0; c < 110; c++) begin
            if (c == 101) check("D_first_ts", event_timestamp, 10);
            if (c == 102) begin
                check("D_valid", event_valid, 1);
                check("D_second_ts", event_timestamp, 68);
                check("D_drop", drop_count, 0);
            end
            run_cycle(c == 10 || c == 68, 1'b1, c == 101, 16'(c));
        end

        // Abort by enable low in SHAPE.
        do_reset();
        for (int c = 0; c < 70; c++) begin
            if (c == 25) check("E_pulse_before", pulse_time, 1);
            if (c == 26) check("E_pulse_fall", pulse_time, 0);
            if (c == 49) check("E_busy_holdoff", busy, 1);
            if (c == 50) check("E_idle", busy, 0);
            if (c == 60) check("E_no_event", event_valid, 0);
            run_cycle(c == 10, c != 25, 1'b1, 16'(c));
        end

        // Asynchronous reset with an event pending and a drop recorded.
        do_reset();
        for (int c = 0; c < 141; c++) begin
            if (c == 140) begin
                check("F_pulse_pre", pulse_time, 1);
                check("F_valid_pre", event_valid, 1);
                check("F_drop_pre",  drop_count, 1);
                reset = 1'b0;
                #1;
                check_all_zero("F_async");
                break;
            end
            run_cycle(c == 10 || c == 68 || c == 130, 1'b1, 1'b0, 16'(c));
        end
        do_reset();
        for (int c = 0; c < 50; c++) begin
            if (c == 39) begin
                check("F_resume_valid", event_valid, 1);
                check("F_resume_ts", event_timestamp, 5);
            end
            run_cycle(c == 5, 1'b1, 1'b0, 16'(c));
        end

        // Timestamp wrap on the 8-bit copy.
        do_reset();
        for (int c = 0; c < 360; c++) begin
            if (c == 255) check("G_cnt_allones", dut_w.r_ts_cnt, 8'hFF);
            if (c == 256) check("G_cnt_wrapped", dut_w.r_ts_cnt, 8'h00);
            if (c == 289) begin
                check("G_w_ts_allones", w_event_timestamp, 8'hFF);
                check("G_ts_full", event_timestamp, 255);
            end
            if (c == 354) check("G_w_ts_after_wrap", w_event_timestamp, 8'd64);
            run_cycle(c == 255 || c == 320, 1'b1, 1'b1, 16'(c));
        end

        // Random traffic against the model.
        do_reset();
        rdy_mode = 1;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) rdy_mode = $urandom_range(0, 2);
            run_cycle($urandom_range(0, 15) == 0,
                      $urandom_range(0, 99) != 0,
                      (rdy_mode == 0) ? 1'b0 :
                      (rdy_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1)),
                      16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
